// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the instruction cache and decode.
// Captures multi-word fetch responses (up to 8 words per response), tags each
// word with its PC, and issues one {pc, inst} per cycle to decode. req_allow is
// the credit that keeps any response from overflowing the ring. A flush empties
// the queue and arranges for responses still in flight to be discarded.
// Build option: define FQ_STAT_EN to add the stat_empty_cyc and
// stat_drop_words counters and their output ports.
module inst_fetch_queue #(
    parameter int DEPTH        = 32,
    parameter int PTR_W        = 5,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_fire,
    input  logic [31:0]      req_pc,
    output logic             req_allow,
    input  logic             resp_valid,
    input  logic [255:0]     resp_data,
    input  logic [3:0]       resp_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    input  logic             flush,
    output logic [PTR_W:0]   count
`ifdef FQ_STAT_EN
    ,
    output logic [31:0]      stat_empty_cyc,
    output logic [31:0]      stat_drop_words
`endif
);

    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PF_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [IF_W-1:0]  inflight_q, inflight_d, drop_q, drop_d, infl_step;
    logic [31:0]      pcf_q [MAX_INFLIGHT];
    logic [31:0]      pcf_d [MAX_INFLIGHT];
    logic [PF_W-1:0]  pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;
    logic             pop, accept;
    logic [31:0]      pc_head;

    function automatic logic [PF_W-1:0] pf_next(input logic [PF_W-1:0] p);
        return (p == PF_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop       = (count_q != '0) && out_ready;
    // A response fills the ring only when no flush is discarding it and no
    // discards from an earlier flush are still owed.
    assign accept    = resp_valid && !flush && (drop_q == '0);
    assign pc_head   = pcf_q[pcf_rd_q];
    assign infl_step = IF_W'(int'(inflight_q) + int'(req_fire) - int'(resp_valid));

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? mem_q[head_q][63:32] : '0;
    assign out_inst  = out_valid ? mem_q[head_q][31:0]  : '0;
    assign count     = count_q;
    // Credit from registered state only: room for a full 8-word response for
    // every outstanding request plus the one about to be issued.
    assign req_allow = (int'(inflight_q) < MAX_INFLIGHT) &&
                       (DEPTH - int'(count_q) >= 8 * (int'(inflight_q) + 1));

    // Next-state for pointers, occupancy, in-flight tracking and the PC FIFO.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = infl_step;
        drop_d     = drop_q;
        pcf_d      = pcf_q;
        pcf_rd_d   = pcf_rd_q;
        pcf_wr_d   = pcf_wr_q;
        if (flush) begin
            // Everything already requested, including this cycle's request,
            // comes back as a response that must be thrown away.
            head_d   = tail_q;
            count_d  = '0;
            drop_d   = infl_step;
            pcf_rd_d = '0;
            pcf_wr_d = '0;
        end else begin
            if (resp_valid && drop_q != '0)
                drop_d = drop_q - 1'b1;
            if (req_fire) begin
                pcf_d[pcf_wr_q] = req_pc;
                pcf_wr_d        = pf_next(pcf_wr_q);
            end
            if (accept) begin
                pcf_rd_d = pf_next(pcf_rd_q);
                tail_d   = tail_q + PTR_W'(resp_num);
            end
            if (pop)
                head_d = head_q + 1'b1;
            count_d = (PTR_W+1)'(int'(count_q) + (accept ? int'(resp_num) : 0) - (pop ? 1 : 0));
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            pcf_rd_q   <= '0;
            pcf_wr_q   <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) pcf_q[i] <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            pcf_rd_q   <= pcf_rd_d;
            pcf_wr_q   <= pcf_wr_d;
            pcf_q      <= pcf_d;
        end
    end

    // Data ring write: word i of an accepted response lands at tail+i with pc P+4i.
    always_ff @(posedge clk) begin
        // NOTE: the ring is not reset; entries are only read while count says they hold data.
        if (!reset && accept) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < resp_num)
                    mem_q[tail_q + PTR_W'(i)] <= {pc_head + 32'(4 * i), resp_data[32*i +: 32]};
            end
        end
    end

`ifdef FQ_STAT_EN
    logic [31:0] stat_empty_cyc_q, stat_empty_cyc_d;
    logic [31:0] stat_drop_words_q, stat_drop_words_d;

    // Statistics: saturating idle-cycle count and wrapping discarded-word count.
    always_comb begin
        stat_empty_cyc_d  = stat_empty_cyc_q;
        stat_drop_words_d = stat_drop_words_q;
        if (!out_valid && !flush && stat_empty_cyc_q != 32'hFFFF_FFFF)
            stat_empty_cyc_d = stat_empty_cyc_q + 1'b1;
        if (resp_valid && (flush || drop_q != '0))
            stat_drop_words_d = stat_drop_words_q + 32'(resp_num);
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_empty_cyc_q  <= '0;
            stat_drop_words_q <= '0;
        end else begin
            stat_empty_cyc_q  <= stat_empty_cyc_d;
            stat_drop_words_q <= stat_drop_words_d;
        end
    end

    assign stat_empty_cyc  = stat_empty_cyc_q;
    assign stat_drop_words = stat_drop_words_q;
`endif

endmodule
